fetch_server: RTL and testbench

- Parametrised successor to the processor's PC/instruction-memory block.
- Holds a word-addressed instruction memory with a load port and a fetch PC that supports redirect (jump) and halt.
- Adds a FQ_DEPTH-entry fetch queue with a valid/ready handshake toward decode, so fetch and decode are decoupled.
- Sits between the memory loader/testbench and the decode stage.

---
 rtl/fetch_server.sv | 153 +++++++++++++++
 tb/tb_fetch_server.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_server.sv
// rtl/fetch_server.sv - instruction memory, redirectable fetch PC and a decoupling fetch queue toward decode.
// Define FETCH_HALT_DETECT_EN to stop fetch after a HALT opcode and expose the sticky halted output.
module fetch_server #(
    parameter int             XLEN       = 32,
    parameter int             IMEM_DEPTH = 64,
    parameter int             FQ_DEPTH   = 2,
    parameter logic [XLEN-1:0] NOP_WORD  = 32'h00000013
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hlt,
    input  logic                          jump,
    input  logic [XLEN-1:0]               next,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               instruction,
    output logic [XLEN-1:0]               PC,
    output logic [XLEN-1:0]               nextPC,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata,
    output logic [$clog2(FQ_DEPTH):0]     fq_count
`ifdef FETCH_HALT_DETECT_EN
    ,
    output logic                          halted
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

    logic [XLEN-1:0] imem    [IMEM_DEPTH];
    logic [XLEN-1:0] fq_word [FQ_DEPTH];
    logic [XLEN-1:0] fq_pc   [FQ_DEPTH];

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            valid;
    logic            full;
    logic            pop;
    logic            push;
    logic            stall;
    logic            in_range;
    logic [XLEN-1:0] fetch_word;
    logic [XLEN-1:0] head_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_range   = (fpc_q < XLEN'(IMEM_DEPTH));
    assign fetch_word = in_range ? imem[fpc_q[AW-1:0]] : NOP_WORD;

    assign valid   = (count_q != '0);
    assign full    = (count_q == CW'(FQ_DEPTH));
    assign head_pc = fq_pc[rd_ptr_q];

    // A pop in the jump cycle is swallowed by the flush rather than advancing the read pointer.
    assign pop  = valid && out_ready && !jump;
    assign push = !jump && !stall && (!full || pop);

`ifdef FETCH_HALT_DETECT_EN
    logic halted_q, halted_d;

    assign stall  = hlt || halted_q;
    assign halted = halted_q;
`else
    assign stall = hlt;
`endif

    always_comb begin
        fpc_d     = fpc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        last_pc_d = valid ? head_pc : last_pc_q;
`ifdef FETCH_HALT_DETECT_EN
        halted_d  = halted_q;
`endif
        if (jump) begin
            fpc_d    = next;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
`ifdef FETCH_HALT_DETECT_EN
            halted_d = 1'b0;
`endif
        end else begin
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                fpc_d    = fpc_q + XLEN'(1);
`ifdef FETCH_HALT_DETECT_EN
                if (fetch_word[6:0] == 7'b1111111) begin
                    halted_d = 1'b1;
                end
`endif
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q     <= '0;
            last_pc_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
`ifdef FETCH_HALT_DETECT_EN
            halted_q  <= 1'b0;
`endif
        end else begin
            fpc_q     <= fpc_d;
            last_pc_q <= last_pc_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
`ifdef FETCH_HALT_DETECT_EN
            halted_q  <= halted_d;
`endif
        end
    end

    // Storage arrays are not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
        if (push) begin
            fq_word[wr_ptr_q] <= fetch_word;
            fq_pc[wr_ptr_q]   <= fpc_q;
        end
    end

    assign out_valid   = valid;
    assign instruction = valid ? fq_word[rd_ptr_q] : NOP_WORD;
    assign PC          = valid ? head_pc : last_pc_q;
    assign nextPC      = PC + XLEN'(1);
    assign fq_count    = count_q;

endmodule

// File: tb/tb_fetch_server.sv
// tb/tb_fetch_server.sv - directed vector table and randomized model comparison for fetch_server.
module tb_fetch_server;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hlt;
    logic        jump;
    logic [31:0] next;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] PC;
    logic [31:0] nextPC;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [1:0]  fq_count;
`ifdef FETCH_HALT_DETECT_EN
    logic        halted;
`endif

    fetch_server dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hlt         (hlt),
        .jump        (jump),
        .next        (next),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .PC          (PC),
        .nextPC      (nextPC),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .fq_count    (fq_count)
`ifdef FETCH_HALT_DETECT_EN
        ,
        .halted      (halted)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        h;
        logic        j;
        logic [31:0] nx;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        int          ecnt;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    vec_t        vt[$];
    ent_t        mq[$];
    logic [31:0] mmem[64];
    logic [31:0] mfpc;
    logic [31:0] mlast;
    bit          mhalted;

    function automatic logic [31:0] ival(input int i);
        return 32'h100 + 32'(i);
    endfunction

    function automatic void addv(input logic h, input logic j, input logic [31:0] nx, input logic r,
                                 input logic ev, input logic [31:0] epc, input logic [31:0] ein, input int ec);
        vt.push_back('{h, j, nx, r, ev, epc, ein, ec});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] ein, input int ec);
        logic [31:0] enpc;
        enpc = epc + 32'd1;
        check({tag, "_valid"}, 64'(out_valid), 64'(ev));
        check({tag, "_instr"}, 64'(instruction), 64'(ein));
        check({tag, "_pc"}, 64'(PC), 64'(epc));
        check({tag, "_nextpc"}, 64'(nextPC), 64'(enpc));
        check({tag, "_count"}, 64'(fq_count), 64'(ec));
    endtask

    task automatic check_model(input string tag);
        logic        v;
        logic [31:0] epc;
        logic [31:0] ein;
        v   = (mq.size() > 0);
        epc = v ? mq[0].pc : mlast;
        ein = v ? mq[0].w : NOP;
        chk_out(tag, v, epc, ein, mq.size());
`ifdef FETCH_HALT_DETECT_EN
        check({tag, "_halted"}, 64'(halted), 64'(mhalted));
`endif
    endtask

    function automatic void model_step(input logic h, input logic j, input logic [31:0] nx, input logic r,
                                       input logic we, input logic [5:0] wa, input logic [31:0] wd);
        bit          v;
        bit          pop;
        bit          push;
        logic [31:0] w;
        v = (mq.size() > 0);
        if (v) mlast = mq[0].pc;
        w = (mfpc < 32'd64) ? mmem[mfpc[5:0]] : NOP;
        if (j) begin
            mq.delete();
            mfpc    = nx;
            mhalted = 0;
        end else begin
            pop  = v && r;
            push = !h && !mhalted && (mq.size() < 2 || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{w, mfpc});
                mfpc = mfpc + 32'd1;
`ifdef FETCH_HALT_DETECT_EN
                if (w[6:0] == 7'h7F) mhalted = 1;
`endif
            end
        end
        if (we) mmem[wa] = wd;
    endfunction

    task automatic drive(input logic h, input logic j, input logic [31:0] nx, input logic r);
        hlt = h; jump = j; next = nx; out_ready = r;
    endtask

    initial begin
        rst_n = 1'b0; hlt = 1'b0; jump = 1'b0; next = '0; out_ready = 1'b0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

        // Vectors: inputs for one cycle, outputs expected after that posedge.
        addv(0, 0, 0, 0, 1, 0, ival(0), 1);
        addv(0, 0, 0, 0, 1, 0, ival(0), 2);
        addv(0, 0, 0, 0, 1, 0, ival(0), 2);
        addv(0, 0, 0, 0, 1, 0, ival(0), 2);
        addv(0, 0, 0, 0, 1, 0, ival(0), 2);
        addv(0, 0, 0, 1, 1, 1, ival(1), 2);
        addv(0, 0, 0, 1, 1, 2, ival(2), 2);
        addv(0, 0, 0, 1, 1, 3, ival(3), 2);
        addv(0, 0, 0, 1, 1, 4, ival(4), 2);
        addv(0, 1, 20, 1, 0, 4, NOP, 0);
        addv(0, 0, 0, 0, 1, 20, ival(20), 1);
        addv(0, 0, 0, 0, 1, 20, ival(20), 2);
        addv(1, 0, 0, 1, 1, 21, ival(21), 1);
        addv(1, 0, 0, 1, 0, 21, NOP, 0);
        addv(1, 0, 0, 1, 0, 21, NOP, 0);
        addv(0, 0, 0, 1, 1, 22, ival(22), 1);
        addv(0, 1, 70, 1, 0, 22, NOP, 0);
        addv(0, 0, 0, 0, 1, 70, NOP, 1);
        addv(1, 1, 5, 0, 0, 70, NOP, 0);
        addv(1, 0, 0, 0, 0, 70, NOP, 0);
        addv(0, 0, 0, 0, 1, 5, ival(5), 1);
        addv(0, 0, 0, 1, 1, 6, ival(6), 1);

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = ival(i);
            mmem[i] = ival(i);
        end
        @(negedge clk);
        imem_we = 1'b0;
        chk_out("reset", 1'b0, 32'd0, NOP, 0);

        rst_n = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].h, vt[i].j, vt[i].nx, vt[i].rdy);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].ein, vt[i].ecnt);
        end

        // Write and fetch of address 7 in the same cycle: fetch sees the old word.
        drive(0, 0, 0, 1);
        imem_we = 1'b1; imem_waddr = 6'd7; imem_wdata = 32'h0000ABCD;
        mmem[7] = 32'h0000ABCD;
        @(negedge clk);
        imem_we = 1'b0;
        chk_out("wr_old", 1'b1, 32'd7, ival(7), 1);
        @(negedge clk);
        chk_out("wr_seq", 1'b1, 32'd8, ival(8), 1);
        drive(0, 1, 7, 1);
        @(negedge clk);
        chk_out("wr_jmp", 1'b0, 32'd8, NOP, 0);
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk_out("wr_new", 1'b1, 32'd7, 32'h0000ABCD, 1);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 1'b0, 32'd0, NOP, 0);

`ifdef FETCH_HALT_DETECT_EN
        check("async_rst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        imem_we = 1'b1; imem_waddr = 6'd3; imem_wdata = 32'h0000007F;
        mmem[3] = 32'h0000007F;
        @(negedge clk);
        imem_we = 1'b0;
        drive(0, 0, 0, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_out($sformatf("hd%0d", i), 1'b1, 32'(i), mmem[i], 1);
            check($sformatf("hd%0d_halted", i), 64'(halted), (i == 3) ? 64'd1 : 64'd0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_out($sformatf("hd_stop%0d", i), 1'b0, 32'd3, NOP, 0);
            check($sformatf("hd_stop%0d_halted", i), 64'(halted), 64'd1);
        end
        drive(0, 1, 0, 1);
        @(negedge clk);
        chk_out("hd_jmp", 1'b0, 32'd3, NOP, 0);
        check("hd_jmp_halted", 64'(halted), 64'd0);
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk_out("hd_restart", 1'b0 | 1'b1, 32'd0, mmem[0], 1);
        check("hd_restart_halted", 64'(halted), 64'd0);
        rst_n = 1'b0;
`endif

        mq.delete();
        mfpc = '0; mlast = '0; mhalted = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic        h, j, r, we;
            logic [31:0] nx, wd;
            logic [5:0]  wa;
            int          sel;
            check_model($sformatf("rnd%0d", i));
            h   = ($urandom % 5) == 0;
            j   = ($urandom % 12) == 0;
            r   = ($urandom % 3) != 0;
            we  = ($urandom % 4) == 0;
            wa  = 6'($urandom % 64);
            wd  = $urandom;
            sel = $urandom % 10;
            if (sel < 7)      nx = 32'($urandom % 64);
            else if (sel < 9) nx = 32'd64 + 32'($urandom % 16);
            else              nx = 32'hFFFFFFFE + 32'($urandom % 2);
            drive(h, j, nx, r);
            imem_we = we; imem_waddr = wa; imem_wdata = wd;
            model_step(h, j, nx, r, we, wa, wd);
            @(negedge clk);
        end
        check_model("rnd_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
